dram_burst_bridge: RTL
======================

// Module: dram_burst_bridge
// PURPOSE
//  Parametrised MemoryBus-slave -> AXI3 master bridge for the DRAM port; successor to the single-beat DRAM bridge.
//  Each bus request is one INCR burst of BURST_LEN beats. Read data is buffered in a credit-checked FIFO so RREADY
//  never stalls DRAM. Write responses are tracked. Sits between the memory arbiter and the PS HP port.
// PARAMETERS
//  DATA_W       32  data width, 32 or 64; arsize/awsize = log2(DATA_W/8)
//  ID_W         6   transaction ID width
//  BURST_LEN    4   beats per burst, 1..16; arlen = awlen = BURST_LEN-1
//  RFIFO_DEPTH  16  read-data FIFO entries, power of 2, >= BURST_LEN
//  MAX_WR_OUT   4   maximum writes awaiting a B response
// PORTS
//  clock        in   1       system clock
//  reset_n      in   1       asynchronous, active-low reset
//  ms_valid/ms_taken in/out 1 request handshake; a beat transfers when both are high
//  ms_write     in   1       1 = write burst, 0 = read burst
//  ms_address   in   32      byte address; used on first beat only
//  ms_data      in   DATA_W  write data, one beat per transfer
//  ms_id        in   ID_W    request ID; used on first beat only
//  sm_valid/sm_taken out/in 1 response handshake; held until taken
//  sm_data      out  DATA_W  read data
//  sm_id        out  ID_W    ID of the response
//  sm_write     out  1       1 = write acknowledge (WRITE_ACK_EN only, else tied 0)
//  resp_err     out  1       sticky; set on any rresp/bresp != OKAY
//  AXI3 master  AR*/AW*/W*/R*/B* channels, flat ports, widths per parameters
//   Constants: burst=01, lock=0, cache=0011, prot=0, qos=0, wstrb all ones
// BEHAVIOUR
//  Reset: all valid/ready outputs 0; FSM IDLE; FIFO empty; counters 0; resp_err 0.
//   Reset takes effect immediately mid-burst; in-flight AXI traffic is discarded.
//  FSM states: IDLE, RD_ADDR, WR_ADDR, WR_DATA.
//   IDLE, read request, credit ok: ms_taken=1 for one cycle; latch address/ID; go to RD_ADDR.
//    credit ok = rd_pending + BURST_LEN <= RFIFO_DEPTH.
//    If credit is short, ms_taken stays 0 and the request waits.
//   RD_ADDR: arvalid=1 until arready; rd_pending += BURST_LEN at AR issue; return to IDLE.
//   IDLE, write request, wr_out < MAX_WR_OUT: do not take the beat yet; latch address/ID; go to WR_ADDR.
//   WR_ADDR: awvalid=1 until awready; beat counter = 0; go to WR_DATA.
//   WR_DATA: wvalid = ms_valid; ms_taken = wready; wdata = ms_data.
//    wlast=1 when beat counter == BURST_LEN-1; after the last beat goes, return to IDLE.
//    ms_write is ignored on beats after the first.
//  AR and AW are never asserted in the same cycle; one burst's address plus data finish before the next is taken.
//  ms_taken is combinational only in WR_DATA; in the other states it is registered.
//  Read return path:
//   rready = FIFO not full. Never deasserts in practice because the credit check guarantees space.
//   Each R beat pushes {rid, rdata} and decrements rd_pending on the pop that drains it.
//   rlast is not checked beyond the error flag.
//   FIFO head drives sm_valid/sm_data/sm_id; pop when sm_valid && sm_taken.
//   FIFO latency: R beat to sm_valid is 1 cycle. Push and pop in the same cycle when full are legal.
//  Write responses:
//   wr_out increments on AW handshake and decrements on B handshake.
//   If both happen in the same cycle, the count is unchanged.
//  resp_err is set by any R or B handshake with resp != 2'b00; it is cleared only by reset.
// CONFIGURATION
//  DRAM_BRIDGE_WRITE_ACK_EN defined:
//   A B handshake loads a one-entry ack register {bid}; bready = register empty.
//   sm port priority: ack register over FIFO head; sm_write=1 and sm_data=0 for an ack.
//  DRAM_BRIDGE_WRITE_ACK_EN undefined:
//   bready tied 1; no ack register; sm_write tied 0.
// TESTING
//  1 Read, BURST_LEN=4, id 5, addr 0x100:
//    -> araddr=0x100, arlen=3, arsize=2; 4 R beats -> 4 sm beats with sm_id=5, same order.
//  2 Four back-to-back reads with sm_taken=0, RFIFO_DEPTH=16:
//    -> 4 ARs issued; 5th read not taken until a pop frees 4 credits.
//  3 Write id 9, data 1,2,3,4, wready low 2 cycles on beat 2:
//    -> awlen=3; W beats 1..4; wlast only on beat 4; ms_taken follows wready.
//  4 Five writes, bvalid held low -> 5th stalls in IDLE; one B -> 5th AW issues.
//  5 rresp=2'b10 on one beat -> resp_err=1 and stays 1; data still delivered.
//  6 reset_n low mid-WR_DATA -> all valids 0 that cycle; new read proceeds normally after release.
//    With WRITE_ACK_EN: B and R arrive the same cycle -> ack presented first with sm_write=1.

Source files
------------

// File: rtl/dram_burst_bridge_if.sv
// dram_burst_bridge_if
// Memory-bus side of the DRAM burst bridge: request (ms_*) and response (sm_*)
// handshakes between the memory arbiter and the bridge.
//   ms_valid/ms_taken  request handshake, beat moves when both high
//   ms_write           1 = write burst, 0 = read burst
//   ms_address, ms_id  first-beat address and transaction ID
//   ms_data            write data, one beat per transfer
//   sm_valid/sm_taken  response handshake, held until taken
//   sm_data, sm_id     read data and its ID
//   sm_write           1 = write acknowledge
// Modports: slave = bridge view, master = arbiter view.
interface dram_burst_bridge_if #(
  parameter int DATA_W = 32,
  parameter int ID_W   = 6
);
  logic              ms_valid;
  logic              ms_taken;
  logic              ms_write;
  logic [31:0]       ms_address;
  logic [DATA_W-1:0] ms_data;
  logic [ID_W-1:0]   ms_id;
  logic              sm_valid;
  logic              sm_taken;
  logic              sm_write;
  logic [DATA_W-1:0] sm_data;
  logic [ID_W-1:0]   sm_id;

  modport slave (
    input  ms_valid, ms_write, ms_address, ms_data, ms_id, sm_taken,
    output ms_taken, sm_valid, sm_data, sm_id, sm_write
  );

  modport master (
    output ms_valid, ms_write, ms_address, ms_data, ms_id, sm_taken,
    input  ms_taken, sm_valid, sm_data, sm_id, sm_write
  );
endinterface

// File: rtl/dram_burst_bridge.sv
// dram_burst_bridge
// Memory-bus slave to AXI3 master bridge for the DRAM port. Every bus request
// becomes one INCR burst of BURST_LEN beats. Read beats land in a FIFO whose
// space is reserved up front (credit check) so rready never throttles DRAM.
// Outstanding writes are counted and capped at MAX_WR_OUT.
// Ports:
//   clock, reset_n     system clock, asynchronous active-low reset
//   bus                memory-bus request/response (dram_burst_bridge_if.slave)
//   resp_err           sticky, set by any R/B response other than OKAY
//   ar*/aw*/w*/r*/b*   AXI3 master channels
// Build option: define DRAM_BRIDGE_WRITE_ACK_EN to report B responses on the
// sm port (sm_write=1) through a one-entry ack register; otherwise bready is
// always high once out of reset and sm_write is 0.
//
// state   | meaning
// IDLE    | waiting for a request that has read credit / write slot
// RD_ADDR | request taken, presenting AR until arready
// WR_ADDR | address latched, presenting AW until awready
// WR_DATA | forwarding write beats straight from ms_* to W
module dram_burst_bridge #(
  parameter int DATA_W      = 32,
  parameter int ID_W        = 6,
  parameter int BURST_LEN   = 4,
  parameter int RFIFO_DEPTH = 16,
  parameter int MAX_WR_OUT  = 4
) (
  input  logic                clock,
  input  logic                reset_n,
  dram_burst_bridge_if.slave  bus,
  output logic                resp_err,
  output logic [ID_W-1:0]     arid,
  output logic [31:0]         araddr,
  output logic [3:0]          arlen,
  output logic [2:0]          arsize,
  output logic [1:0]          arburst,
  output logic [1:0]          arlock,
  output logic [3:0]          arcache,
  output logic [2:0]          arprot,
  output logic [3:0]          arqos,
  output logic                arvalid,
  input  logic                arready,
  output logic [ID_W-1:0]     awid,
  output logic [31:0]         awaddr,
  output logic [3:0]          awlen,
  output logic [2:0]          awsize,
  output logic [1:0]          awburst,
  output logic [1:0]          awlock,
  output logic [3:0]          awcache,
  output logic [2:0]          awprot,
  output logic [3:0]          awqos,
  output logic                awvalid,
  input  logic                awready,
  output logic [ID_W-1:0]     wid,
  output logic [DATA_W-1:0]   wdata,
  output logic [DATA_W/8-1:0] wstrb,
  output logic                wlast,
  output logic                wvalid,
  input  logic                wready,
  input  logic [ID_W-1:0]     rid,
  input  logic [DATA_W-1:0]   rdata,
  input  logic [1:0]          rresp,
  input  logic                rlast,
  input  logic                rvalid,
  output logic                rready,
  input  logic [ID_W-1:0]     bid,
  input  logic [1:0]          bresp,
  input  logic                bvalid,
  output logic                bready
);
  localparam int PW = $clog2(RFIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = ID_W + DATA_W;
  localparam int OW = $clog2(MAX_WR_OUT + 1);
  localparam logic [3:0]    AXLEN     = 4'(BURST_LEN - 1);
  localparam logic [2:0]    AXSIZE    = 3'($clog2(DATA_W / 8));
  localparam logic [CW-1:0] BL_CREDIT = CW'(BURST_LEN);
  localparam logic [CW-1:0] DEPTH_C   = CW'(RFIFO_DEPTH);
  localparam logic [OW-1:0] MAX_OUT   = OW'(MAX_WR_OUT);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] RD_ADDR = 2'd1;
  localparam logic [1:0] WR_ADDR = 2'd2;
  localparam logic [1:0] WR_DATA = 2'd3;

  logic [1:0]      state;
  logic [31:0]     addr_q;
  logic [ID_W-1:0] id_q;
  logic [3:0]      beat_q;
  logic            taken_q;
  logic            rdy_en;
  logic [CW-1:0]   rd_pending;
  logic [OW-1:0]   wr_out;
  logic            credit_ok;

  logic [EW-1:0]   fifo_mem [RFIFO_DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   fifo_cnt;
  logic [EW-1:0]   fifo_head;
  logic            fifo_empty, fifo_full, fifo_push, fifo_pop;

  logic ar_hs, aw_hs, w_hs, r_hs, b_hs;

  assign ar_hs = arvalid & arready;
  assign aw_hs = awvalid & awready;
  assign w_hs  = wvalid & wready;
  assign r_hs  = rvalid & rready;
  assign b_hs  = bvalid & bready;

  // rd_pending counts beats requested but not yet popped, so a new burst is
  // only accepted when the FIFO is guaranteed room for all of its beats.
  assign credit_ok = (32'(rd_pending) + 32'(BURST_LEN)) <= 32'(RFIFO_DEPTH);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state   <= IDLE;
      taken_q <= 1'b0;
      addr_q  <= '0;
      id_q    <= '0;
      beat_q  <= '0;
    end else begin
      taken_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.ms_valid) begin
            if (!bus.ms_write && credit_ok) begin
              state   <= RD_ADDR;
              taken_q <= 1'b1;
              addr_q  <= bus.ms_address;
              id_q    <= bus.ms_id;
            end else if (bus.ms_write && (wr_out < MAX_OUT)) begin
              // Write beats are taken later, straight onto W.
              state  <= WR_ADDR;
              addr_q <= bus.ms_address;
              id_q   <= bus.ms_id;
            end
          end
        end
        RD_ADDR: if (arready) state <= IDLE;
        WR_ADDR: begin
          if (awready) begin
            state  <= WR_DATA;
            beat_q <= '0;
          end
        end
        WR_DATA: begin
          if (w_hs) begin
            beat_q <= beat_q + 4'd1;
            if (wlast) state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Keeps every ready low while reset is applied and for the first edge after.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) rdy_en <= 1'b0;
    else          rdy_en <= 1'b1;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rd_pending <= '0;
      wr_out     <= '0;
      resp_err   <= 1'b0;
    end else begin
      rd_pending <= rd_pending + (ar_hs ? BL_CREDIT : '0) - (fifo_pop ? CW'(1) : '0);
      case ({aw_hs, b_hs})
        2'b10:   wr_out <= wr_out + OW'(1);
        2'b01:   wr_out <= wr_out - OW'(1);
        default: wr_out <= wr_out;
      endcase
      if ((r_hs && rresp != 2'b00) || (b_hs && bresp != 2'b00)) resp_err <= 1'b1;
    end
  end

  assign arvalid = (state == RD_ADDR);
  assign awvalid = (state == WR_ADDR);
  assign wvalid  = (state == WR_DATA) && bus.ms_valid;
  assign wlast   = (state == WR_DATA) && (beat_q == AXLEN);
  assign wdata   = bus.ms_data;
  assign wid     = id_q;
  assign wstrb   = '1;
  assign bus.ms_taken = (state == WR_DATA) ? wready : taken_q;

  assign arid    = id_q;
  assign araddr  = addr_q;
  assign arlen   = AXLEN;
  assign arsize  = AXSIZE;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0011;
  assign arprot  = 3'b000;
  assign arqos   = 4'b0000;
  assign awid    = id_q;
  assign awaddr  = addr_q;
  assign awlen   = AXLEN;
  assign awsize  = AXSIZE;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'b0011;
  assign awprot  = 3'b000;
  assign awqos   = 4'b0000;

  // Read-data FIFO; pointers wrap naturally because the depth is a power of 2.
  assign fifo_empty = (fifo_cnt == '0);
  assign fifo_full  = (fifo_cnt == DEPTH_C);
  assign fifo_push  = r_hs;
  assign rready     = rdy_en & ~fifo_full;
  assign fifo_head  = fifo_mem[rd_ptr];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      fifo_cnt <= '0;
    end else begin
      if (fifo_push) wr_ptr <= wr_ptr + 1'b1;
      if (fifo_pop)  rd_ptr <= rd_ptr + 1'b1;
      fifo_cnt <= fifo_cnt + (fifo_push ? CW'(1) : '0) - (fifo_pop ? CW'(1) : '0);
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_push) fifo_mem[wr_ptr] <= {rid, rdata};
  end

  // rlast carries no information beyond the beat count, which is fixed.
  logic unused_rlast;
  assign unused_rlast = rlast;

`ifdef DRAM_BRIDGE_WRITE_ACK_EN
  logic            ack_valid;
  logic [ID_W-1:0] ack_id;

  assign bready = rdy_en & ~ack_valid;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      ack_valid <= 1'b0;
      ack_id    <= '0;
    end else if (b_hs) begin
      ack_valid <= 1'b1;
      ack_id    <= bid;
    end else if (ack_valid && bus.sm_taken) begin
      ack_valid <= 1'b0;
    end
  end

  // A pending ack wins the sm port; read data waits behind it.
  assign bus.sm_valid = ack_valid | ~fifo_empty;
  assign bus.sm_write = ack_valid;
  assign bus.sm_id    = ack_valid ? ack_id : fifo_head[EW-1:DATA_W];
  assign bus.sm_data  = ack_valid ? '0 : fifo_head[DATA_W-1:0];
  assign fifo_pop     = ~ack_valid & ~fifo_empty & bus.sm_taken;
`else
  assign bready       = rdy_en;
  assign bus.sm_valid = ~fifo_empty;
  assign bus.sm_write = 1'b0;
  assign bus.sm_id    = fifo_head[EW-1:DATA_W];
  assign bus.sm_data  = fifo_head[DATA_W-1:0];
  assign fifo_pop     = ~fifo_empty & bus.sm_taken;

  logic unused_bid;
  assign unused_bid = ^bid;
`endif
endmodule
